ps2_frame_rx: RTL and testbench

PS/2 device-to-host frame receiver feeding the keyboard decoder. It synchronises the raw `ps2Clk`/`ps2Data` pins and samples the 11-bit frame (start, 8 data bits LSB first, odd parity, stop) a fixed delay after each falling clock edge. It polices bit-period timing and presents each valid byte with a level `dataReady` that the decoder edge-detects. Frames that are malformed or time out raise `error` and are discarded.

---
 rtl/ps2_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Synchronises the raw PS/2 pins, samples each bit readAt cycles after a
// falling ps2Clk edge, checks the bit-period timing and frame format, and
// presents each good byte with a level dataReady.
// Ports:
//   clk       system clock, posedge
//   reset     asynchronous active-low reset
//   ps2Clk    raw PS/2 clock pin (asynchronous)
//   ps2Data   raw PS/2 data pin (asynchronous)
//   data      last valid received byte
//   dataReady high from good-frame completion until the next frame starts
//   error     sticky frame error, cleared by the next good frame
//   busy      high while a frame is being received
module ps2_frame_rx #(
    parameter int unsigned counterBits = 8,
    parameter int unsigned minClk      = 15,
    parameter int unsigned maxClk      = 25,
    parameter int unsigned readAt      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       error,
    output logic       busy
);

    localparam int unsigned CW   = counterBits;
    localparam int unsigned IDXW = 4;

    localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]   READ_AT   = CW'(readAt);
    localparam logic [CW-1:0]   MIN_CLK   = CW'(minClk);
    localparam logic [CW-1:0]   MAX_CLK   = CW'(maxClk);
    localparam logic [IDXW-1:0] IDX_START = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_D_END = IDXW'(8);
    localparam logic [IDXW-1:0] IDX_PAR   = IDXW'(9);

    typedef enum logic {IDLE, RECV} state_e;

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic            fall_c;
    logic            samp_c;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      sr_q, sr_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    // Two-flop synchronisers plus edge register; all idle high so reset
    // release never fakes a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2Clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2Data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_c = clk_prev_q & ~clk_s2_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: interval counter, sample strobe, frame sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        par_d   = par_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        samp_c  = 1'b0;

        if (fall_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        samp_c = pend_q && !fall_c && (cnt_q == READ_AT);

        if (fall_c) begin
            pend_d = 1'b1;
        end else if (samp_c) begin
            pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    state_d = RECV;
                    idx_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            RECV: begin
                if (fall_c) begin
                    // Edge-to-edge interval check; the offending edge is consumed.
                    if (idx_q != IDX_START && (cnt_q < MIN_CLK || cnt_q > MAX_CLK)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (samp_c) begin
                    idx_d = idx_q + IDXW'(1);
                    if (idx_q == IDX_START) begin
                        if (dat_s2_q) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (idx_q <= IDX_D_END) begin
                        sr_d = {dat_s2_q, sr_q[7:1]};
                    end else if (idx_q == IDX_PAR) begin
                        par_d = dat_s2_q;
                    end else begin
                        state_d = IDLE;
                        if (dat_s2_q && (^{sr_q, par_q})) begin
                            data_d = sr_q;
                            rdy_d  = 1'b1;
                            err_d  = 1'b0;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end
                end else if (!pend_q && cnt_q == MAX_CLK) begin
                    // Counter is about to exceed maxClk with no edge: timeout.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV);
    end

    assign data      = data_q;
    assign dataReady = rdy_q;
    assign error     = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: scoreboard bench for ps2_frame_rx. Frames are driven on
// the pins, the expected outcome of each frame is queued from a frame-level
// model, and a monitor compares outputs whenever busy drops at frame end.
module tb_ps2_frame_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       err;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       ps2Clk  = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] data;
    logic       dataReady;
    logic       error;
    logic       busy;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         sb_en    = 1'b0;
    logic [7:0] last_good = 8'h00;
    int         drop_cyc[11];
    int         first_drop   = 0;
    int         last_drop    = 0;
    int         rdy_rise_cyc = -1;
    int         rdy_fall_cyc = -1;
    int         err_rise_cyc = -1;
    logic       busy_p = 1'b0;
    logic       rdy_p  = 1'b0;
    logic       err_p  = 1'b0;

    ps2_frame_rx dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .data      (data),
        .dataReady (dataReady),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_flip, input bit stop);
        logic p;
        p = ~(^b) ^ par_flip;
        return {stop, p, b, 1'b0};
    endfunction

    // Device-side driver: data changes while clock is high, then clock falls.
    task automatic send_frame(input logic [10:0] bits, input int nbits, input int period);
        int lo;
        int hi;
        lo = period / 2;
        hi = period - lo;
        for (int i = 0; i < nbits; i++) begin
            ps2Data = bits[i];
            wait_cyc(hi);
            ps2Clk = 1'b0;
            drop_cyc[i] = cyc;
            if (i == 0) first_drop = cyc;
            last_drop = cyc;
            wait_cyc(lo);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    // Frame-level reference: a complete frame with start 0, stop 1 and an odd
    // number of ones over data+parity is good; anything else is an error.
    task automatic expect_frame(input logic [10:0] bits, input int nbits);
        int   ones;
        exp_t e;
        if (nbits == 0) return;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(bits[i]);
        if (nbits == 11 && bits[0] == 1'b0 && bits[10] == 1'b1 && (ones % 2) == 1) begin
            last_good = bits[8:1];
            e = '{data: last_good, rdy: 1'b1, err: 1'b0};
        end else begin
            e = '{data: last_good, rdy: 1'b0, err: 1'b1};
        end
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] b, input bit pf, input bit stop,
                         input int nbits, input int period, input int gap);
        logic [10:0] f;
        f = make_frame(b, pf, stop);
        expect_frame(f, nbits);
        send_frame(f, nbits, period);
        wait_cyc(gap);
    endtask

    // Monitor: every end of frame (busy falling) consumes one expected entry.
    always @(negedge clk) begin
        if (sb_en && busy_p && !busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: frame end with empty queue, data=%02h rdy=%0b err=%0b",
                         data, dataReady, error);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data",  32'(data),      32'(mon_e.data));
                check("sb_ready", 32'(dataReady), 32'(mon_e.rdy));
                check("sb_error", 32'(error),     32'(mon_e.err));
            end
        end
        if (!rdy_p && dataReady) rdy_rise_cyc = cyc;
        if (rdy_p && !dataReady) rdy_fall_cyc = cyc;
        if (!err_p && error)     err_rise_cyc = cyc;
        busy_p = busy;
        rdy_p  = dataReady;
        err_p  = error;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int         kind;
        int         per;

        // Reset state
        wait_cyc(3);
        check("rst_data",  32'(data),      32'h00);
        check("rst_ready", 32'(dataReady), 32'h0);
        check("rst_error", 32'(error),     32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        reset = 1'b1;
        wait_cyc(5);
        sb_en = 1'b1;

        // Single good frame and its latency from the last pin edge
        frame(8'h1C, 1'b0, 1'b1, 11, 20, 40);
        check("t1_ready_latency", 32'(rdy_rise_cyc - last_drop), 32'd9);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // Back-to-back frames; dataReady drops right after the new start edge
        frame(8'hE0, 1'b0, 1'b1, 11, 20, 0);
        frame(8'h75, 1'b0, 1'b1, 11, 20, 40);
        check("t2_ready_fall", 32'(rdy_fall_cyc - first_drop), 32'd3);

        // Parity error, then a good frame clears the error
        frame(8'h1C, 1'b1, 1'b1, 11, 20, 40);
        frame(8'hF0, 1'b0, 1'b1, 11, 20, 40);

        // Too-fast clock: error on the second edge of the frame
        sb_en = 1'b0;
        send_frame(make_frame(8'h1C, 1'b0, 1'b1), 11, 10);
        wait_cyc(60);
        check("t4_fast_err_time", 32'(err_rise_cyc - drop_cyc[1]), 32'd3);
        check("t4_fast_error", 32'(error),     32'h1);
        check("t4_fast_busy",  32'(busy),      32'h0);
        check("t4_fast_data",  32'(data),      32'(last_good));
        check("t4_fast_ready", 32'(dataReady), 32'h0);
        sb_en = 1'b1;
        frame(8'h3C, 1'b0, 1'b1, 11, 20, 40);

        // Too-slow clock
        sb_en = 1'b0;
        send_frame(make_frame(8'h81, 1'b0, 1'b1), 11, 30);
        wait_cyc(60);
        check("t4_slow_error", 32'(error), 32'h1);
        check("t4_slow_busy",  32'(busy),  32'h0);
        check("t4_slow_data",  32'(data),  32'(last_good));
        sb_en = 1'b1;
        frame(8'h42, 1'b0, 1'b1, 11, 20, 40);

        // Bad stop bit
        frame(8'h66, 1'b0, 1'b0, 11, 20, 40);

        // Randomised frames: good, parity error, stop error, truncated
        for (int n = 0; n < 30; n++) begin
            rb   = 8'($urandom);
            kind = int'($urandom_range(0, 8));
            per  = int'($urandom_range(18, 24));
            if (kind <= 5)      frame(rb, 1'b0, 1'b1, 11, per, 40);
            else if (kind == 6) frame(rb, 1'b1, 1'b1, 11, per, 40);
            else if (kind == 7) frame(rb, 1'b0, 1'b0, 11, per, 40);
            else                frame(rb, 1'b0, 1'b1, int'($urandom_range(1, 10)), per, 40);
        end

        // Timeout after 5 bits, then recovery
        frame(8'h33, 1'b0, 1'b1, 11, 20, 40);
        frame(8'h29, 1'b0, 1'b1, 5, 20, 40);
        check("t5_timeout_time", 32'(err_rise_cyc - last_drop), 32'd29);
        check("t5_timeout_busy", 32'(busy), 32'h0);
        frame(8'h29, 1'b0, 1'b1, 11, 20, 40);

        // Reset in the middle of a frame
        sb_en = 1'b0;
        send_frame(make_frame(8'h5A, 1'b0, 1'b1), 4, 20);
        check("t6_busy_before", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_data",  32'(data),      32'h00);
        check("t6_rst_ready", 32'(dataReady), 32'h0);
        check("t6_rst_error", 32'(error),     32'h0);
        check("t6_rst_busy",  32'(busy),      32'h0);
        wait_cyc(3);
        reset = 1'b1;
        last_good = 8'h00;
        wait_cyc(60);
        check("t6_post_error", 32'(error), 32'h0);
        check("t6_post_busy",  32'(busy),  32'h0);
        sb_en = 1'b1;
        frame(8'h5A, 1'b0, 1'b1, 11, 20, 40);
        check("t6_final_data",  32'(data),      32'h5A);
        check("t6_final_ready", 32'(dataReady), 32'h1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
